// File: rtl/ser2par_lanes.sv
// ser2par_lanes: multi-lane serial-to-parallel converter.
// Beats of L bits are packed into W-bit words (N = W/L beats per word).
// A start-of-word marker realigns the beat counter. Finished words go into a
// single holding register with a valid/ready handshake. A word that finishes
// while the holding register is still occupied is dropped and flagged.
//
// W must be an integer multiple of L, and W/L must be at least 2.

module ser2par_lanes #(
    parameter int W         = 8,
    parameter int L         = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [L-1:0] ser_din,
    input  logic         ser_din_valid,
    input  logic         sof,
    output logic [W-1:0] par_dout,
    output logic         par_dout_valid,
    input  logic         par_dout_ready,
    output logic         overflow,
    output logic         frame_err
);

    localparam int N  = W / L;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);

    // Beat counter (index of the next slot) and the in-progress word.
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [W-1:0]  asm_reg;

    // Per-beat decode.
    logic          sof_beat;   // valid beat that restarts the word
    logic          last_beat;  // valid beat that completes a word
    logic          out_free;   // holding register can take a word this edge
    logic          load_word;  // completed word moves to par_dout
    logic          drop_word;  // completed word is lost (output busy)
    logic [CW-1:0] slot_sel;   // slot the current beat is written into
    logic [W-1:0]  base_word;  // word the current beat is merged into
    logic [W-1:0]  merged_word;

    assign sof_beat  = ser_din_valid & sof;
    assign last_beat = ser_din_valid & ~sof & (cnt_reg == LAST_SLOT);
    assign out_free  = ~par_dout_valid | par_dout_ready;
    assign load_word = last_beat & out_free;
    assign drop_word = last_beat & ~out_free;

    // A sof beat always lands in slot 0 of a cleared word, so partial data
    // from an aborted word never leaks into the next one.
    assign slot_sel  = sof_beat ? '0 : cnt_reg;
    assign base_word = sof_beat ? '0 : asm_reg;

    // Merge the incoming beat into its slot. Each slot is a fixed bit range
    // chosen at elaboration time, so the merge is a per-slot 2:1 mux rather
    // than a variable shifter.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            localparam int LO = (MSB_FIRST != 0) ? (W - (gi + 1) * L) : (gi * L);
            assign merged_word[LO +: L] = (slot_sel == CW'(gi)) ? ser_din
                                                                 : base_word[LO +: L];
        end
    endgenerate

    // Next counter value: hold on idle, restart at 1 after sof, wrap after the last slot.
    always_comb begin
        cnt_next = cnt_reg;
        if (ser_din_valid) begin
            if (sof) begin
                cnt_next = CW'(1);
            end else if (cnt_reg == LAST_SLOT) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Beat counter and assembly register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
            asm_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (ser_din_valid) begin
                asm_reg <= merged_word;
            end
        end
    end

    // Output holding register: load a finished word when free, otherwise retire on handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_dout       <= '0;
            par_dout_valid <= 1'b0;
        end else begin
            if (load_word) begin
                par_dout       <= merged_word;
                par_dout_valid <= 1'b1;
            end else if (par_dout_valid && par_dout_ready) begin
                par_dout_valid <= 1'b0;
            end
        end
    end

    // Registered single-cycle status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= drop_word;
            frame_err <= sof_beat && (cnt_reg != '0);
        end
    end

endmodule

// File: tb/tb_ser2par_lanes.sv
// Bench for ser2par_lanes: two instances (W=8, L=2) that differ only in slot
// order share one stimulus stream. A word-level reference model predicts the
// words and per-cycle flags. A monitor compares them against both instances
// whenever a word is handed off, and on every cycle for the flags.

module tb_ser2par_lanes;

    localparam int W = 8;
    localparam int L = 2;
    localparam int N = W / L;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [L-1:0] ser_din = '0;
    logic         ser_din_valid = 1'b0;
    logic         sof = 1'b0;
    logic         par_dout_ready = 1'b0;

    logic [W-1:0] dout_m, dout_l;
    logic         dv_m, dv_l, ovf_m, ovf_l, fe_m, fe_l;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    ser2par_lanes #(.W(W), .L(L), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rstn(rstn), .ser_din(ser_din), .ser_din_valid(ser_din_valid),
        .sof(sof), .par_dout(dout_m), .par_dout_valid(dv_m),
        .par_dout_ready(par_dout_ready), .overflow(ovf_m), .frame_err(fe_m)
    );

    ser2par_lanes #(.W(W), .L(L), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rstn(rstn), .ser_din(ser_din), .ser_din_valid(ser_din_valid),
        .sof(sof), .par_dout(dout_l), .par_dout_valid(dv_l),
        .par_dout_ready(par_dout_ready), .overflow(ovf_l), .frame_err(fe_l)
    );

    typedef struct {
        int   cyc;
        logic valid;
        logic ovf;
        logic ferr;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] word_m_q[$];
    logic [W-1:0] word_l_q[$];

    // Reference model state: beats collected for the current word, and
    // whether the output holds an unconsumed word.
    logic [L-1:0] beats[$];
    logic         occ = 1'b0;

    task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Predict the effect of the upcoming clock edge from the inputs just driven.
    task automatic model_step();
        logic         ferr = 1'b0;
        logic         ovf = 1'b0;
        logic         complete = 1'b0;
        logic [W-1:0] wm = '0;
        logic [W-1:0] wl = '0;
        exp_t         e;
        if (ser_din_valid) begin
            if (sof) begin
                ferr = (beats.size() != 0);
                beats.delete();
            end
            beats.push_back(ser_din);
            if (beats.size() == N) begin
                complete = 1'b1;
                for (int i = 0; i < N; i++) begin
                    wm = (wm << L) | W'(beats[i]);
                    wl = wl | (W'(beats[i]) << (i * L));
                end
                beats.delete();
            end
        end
        if (complete && (!occ || par_dout_ready)) begin
            word_m_q.push_back(wm);
            word_l_q.push_back(wl);
            occ = 1'b1;
        end else begin
            if (complete) ovf = 1'b1;
            if (occ && par_dout_ready) occ = 1'b0;
        end
        e.cyc   = cyc_cnt + 1;
        e.valid = occ;
        e.ovf   = ovf;
        e.ferr  = ferr;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after a rising edge and record the prediction.
    task automatic drive(input logic v, input logic s, input logic [L-1:0] d, input logic r);
        @(posedge clk);
        #1;
        ser_din_valid  = v;
        sof            = s;
        ser_din        = d;
        par_dout_ready = r;
        model_step();
    endtask

    task automatic check_all_zero(input string tag);
        check_w({tag, "_dout_m"}, dout_m, '0);
        check_w({tag, "_dout_l"}, dout_l, '0);
        check_b({tag, "_valid"}, dv_m | dv_l, 1'b0);
        check_b({tag, "_overflow"}, ovf_m | ovf_l, 1'b0);
        check_b({tag, "_frame_err"}, fe_m | fe_l, 1'b0);
    endtask

    // Monitor: per-cycle flag checks and word checks at each handshake.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rstn) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc == cyc_cnt) begin
                    check_b("valid_m", dv_m, mon_e.valid);
                    check_b("valid_l", dv_l, mon_e.valid);
                    check_b("overflow_m", ovf_m, mon_e.ovf);
                    check_b("overflow_l", ovf_l, mon_e.ovf);
                    check_b("frame_err_m", fe_m, mon_e.ferr);
                    check_b("frame_err_l", fe_l, mon_e.ferr);
                end
            end
            if (dv_m && par_dout_ready) begin
                if (word_m_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_m: got unexpected word %h expected none", dout_m);
                end else begin
                    check_w("word_m", dout_m, word_m_q.pop_front());
                end
            end
            if (dv_l && par_dout_ready) begin
                if (word_l_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_l: got unexpected word %h expected none", dout_l);
                end else begin
                    check_w("word_l", dout_l, word_l_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state.
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Four beats with ready high: B1 / 4E, visible one cycle after beat 4.
        drive(1'b1, 1'b0, 2'b10, 1'b1);
        drive(1'b1, 1'b0, 2'b11, 1'b1);
        drive(1'b1, 1'b0, 2'b00, 1'b1);
        drive(1'b1, 1'b0, 2'b01, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        check_w("basic_msb", dout_m, 8'hB1);
        check_w("basic_lsb", dout_l, 8'h4E);
        check_b("basic_valid", dv_m, 1'b1);

        // Two words with ready low: the second is dropped, and A5 stays on the output.
        begin
            logic [L-1:0] seq_a [8] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
            for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, seq_a[i], 1'b0);
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        check_w("ovf_hold_m", dout_m, 8'hA5);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        check_b("ovf_valid_dropped", dv_m, 1'b0);

        // Realignment by sof mid-word: frame_err pulses, and the word is C0 / 03.
        drive(1'b1, 1'b0, 2'b01, 1'b1);
        drive(1'b1, 1'b0, 2'b10, 1'b1);
        drive(1'b1, 1'b1, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'b00, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        check_w("sof_word_m", dout_m, 8'hC0);
        check_w("sof_word_l", dout_l, 8'h03);

        // Sof with valid low is ignored.
        drive(1'b1, 1'b0, 2'b01, 1'b1);
        drive(1'b0, 1'b1, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'b10, 1'b1);

        // Continuous beats with ready high, then beats with gaps.
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, L'($urandom), 1'b1);
        for (int i = 0; i < 40; i++) drive(1'(($urandom_range(0, 2)) != 0), 1'b0, L'($urandom), 1'b1);

        // Reset mid-word: outputs clear at once, and the partial word is discarded.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'b11, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        word_m_q.delete();
        word_l_q.delete();
        beats.delete();
        occ = 1'b0;
        ser_din_valid = 1'b0;
        sof = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'b01, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        check_w("post_reset_m", dout_m, 8'h55);
        check_w("post_reset_l", dout_l, 8'h55);

        // Random traffic: first with mostly-ready output, then with heavy backpressure.
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
                  L'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
                  L'($urandom), 1'($urandom_range(0, 3) == 0));

        // Drain and confirm that every predicted word was delivered.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'b00, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (word_m_q.size() != 0 || word_l_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d undelivered words expected 0/0",
                     word_m_q.size(), word_l_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
